// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphonic voice allocator feeding per-voice Envelope instances. Accepts
//   decoded MIDI note events over valid/ready, picks a voice slot (retrigger,
//   free slot, oldest releasing, oldest held), and drives one-cycle
//   note_on/note_off pulses plus per-voice note/velocity. envelope_end pulses
//   return releasing voices to the free pool.
//
// Ports
//   clock_50_000_000 : system clock
//   reset            : synchronous active-high reset
//   event_valid/ready: event handshake (ready low while reset is high)
//   event_on         : 1 = note-on, 0 = note-off
//   event_note       : MIDI note number
//   event_velocity   : velocity (note-on with velocity 0 acts as note-off)
//   envelope_end     : per-voice end-of-release pulse
//   voice_note_on    : per-voice one-cycle note-on pulse
//   voice_note_off   : per-voice one-cycle note-off pulse
//   voice_note       : packed per-voice note, voice i at [i*NOTE_WIDTH +: NOTE_WIDTH]
//   voice_velocity   : packed per-voice velocity, same packing
//   voice_gate       : voice is HELD
//   voice_active     : voice is HELD or RELEASING
//   steal            : one-cycle pulse, current note-on stole a busy voice
module voice_allocator #(
    parameter int VOICES         = 4,
    parameter int NOTE_WIDTH     = 7,
    parameter int VELOCITY_WIDTH = 7
) (
    input  logic                               clock_50_000_000,
    input  logic                               reset,
    input  logic                               event_valid,
    output logic                               event_ready,
    input  logic                               event_on,
    input  logic [NOTE_WIDTH-1:0]              event_note,
    input  logic [VELOCITY_WIDTH-1:0]          event_velocity,
    input  logic [VOICES-1:0]                  envelope_end,
    output logic [VOICES-1:0]                  voice_note_on,
    output logic [VOICES-1:0]                  voice_note_off,
    output logic [VOICES*NOTE_WIDTH-1:0]       voice_note,
    output logic [VOICES*VELOCITY_WIDTH-1:0]   voice_velocity,
    output logic [VOICES-1:0]                  voice_gate,
    output logic [VOICES-1:0]                  voice_active,
    output logic                               steal
);

    localparam int AW = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_ISSUE} fsm_t;
    typedef enum logic [1:0] {V_FREE, V_HELD, V_REL} vstate_t;

    fsm_t                      r_state;
    fsm_t                      w_next;

    logic                      r_ev_on;
    logic [NOTE_WIDTH-1:0]     r_ev_note;
    logic [VELOCITY_WIDTH-1:0] r_ev_vel;

    vstate_t                   r_vstate [VOICES];
    logic [AW-1:0]             r_age    [VOICES];
    logic [NOTE_WIDTH-1:0]     r_note   [VOICES];
    logic [VELOCITY_WIDTH-1:0] r_vel    [VOICES];

    logic [VOICES-1:0]         r_note_on;
    logic [VOICES-1:0]         r_note_off;
    logic                      r_steal;

    // Target selection candidates
    logic                      w_hit_f,  w_off_f,  w_free_f,  w_rel_f;
    logic [AW-1:0]             w_hit_idx, w_off_idx, w_free_idx, w_rel_idx, w_old_idx;
    logic [AW-1:0]             w_rel_age;
    logic                      w_write;
    logic [AW-1:0]             w_tgt;
    logic                      w_steal;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (event_valid) w_next = ST_LOOKUP;
            ST_LOOKUP: w_next = ST_ISSUE;
            ST_ISSUE:  w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign event_ready = (r_state == ST_IDLE) && !reset;

    // ----------------------------------------------------- target selection
    // Each scan keeps the first hit so the lowest index wins; the releasing
    // scan keeps the largest age. Ages are a permutation, so when every voice
    // is held exactly one carries age VOICES-1.
    always_comb begin
        w_hit_f    = 1'b0;
        w_off_f    = 1'b0;
        w_free_f   = 1'b0;
        w_rel_f    = 1'b0;
        w_hit_idx  = '0;
        w_off_idx  = '0;
        w_free_idx = '0;
        w_rel_idx  = '0;
        w_old_idx  = '0;
        w_rel_age  = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (!w_hit_f && r_vstate[i] != V_FREE && r_note[i] == r_ev_note) begin
                w_hit_f   = 1'b1;
                w_hit_idx = AW'(i);
            end
            if (!w_off_f && r_vstate[i] == V_HELD && r_note[i] == r_ev_note) begin
                w_off_f   = 1'b1;
                w_off_idx = AW'(i);
            end
            if (!w_free_f && r_vstate[i] == V_FREE) begin
                w_free_f   = 1'b1;
                w_free_idx = AW'(i);
            end
            if (r_vstate[i] == V_REL && (!w_rel_f || r_age[i] > w_rel_age)) begin
                w_rel_f   = 1'b1;
                w_rel_idx = AW'(i);
                w_rel_age = r_age[i];
            end
            if (r_vstate[i] == V_HELD && r_age[i] == AW'(VOICES - 1)) begin
                w_old_idx = AW'(i);
            end
        end

        w_write = 1'b0;
        w_tgt   = '0;
        w_steal = 1'b0;
        if (r_ev_on) begin
            w_write = 1'b1;
            if (w_hit_f) begin
                w_tgt = w_hit_idx;
            end else if (w_free_f) begin
                w_tgt = w_free_idx;
            end else if (w_rel_f) begin
                w_tgt   = w_rel_idx;
                w_steal = 1'b1;
            end else begin
                w_tgt   = w_old_idx;
                w_steal = 1'b1;
            end
        end else if (w_off_f) begin
            w_write = 1'b1;
            w_tgt   = w_off_idx;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_ev_on    <= 1'b0;
            r_ev_note  <= '0;
            r_ev_vel   <= '0;
            r_note_on  <= '0;
            r_note_off <= '0;
            r_steal    <= 1'b0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                r_vstate[i] <= V_FREE;
                r_age[i]    <= AW'(i);
                r_note[i]   <= '0;
                r_vel[i]    <= '0;
            end
        end else begin
            r_note_on  <= '0;
            r_note_off <= '0;
            r_steal    <= 1'b0;

            if (r_state == ST_IDLE && event_valid) begin
                r_ev_on   <= event_on && (event_velocity != '0);
                r_ev_note <= event_note;
                r_ev_vel  <= event_velocity;
            end

            for (int unsigned i = 0; i < VOICES; i++) begin
                if (envelope_end[i] && r_vstate[i] == V_REL) begin
                    r_vstate[i] <= V_FREE;
                end
            end

            // Placed after the envelope-end loop so the lookup write to the
            // same voice takes precedence.
            if (r_state == ST_LOOKUP && w_write) begin
                if (r_ev_on) begin
                    for (int unsigned j = 0; j < VOICES; j++) begin
                        if (r_age[j] < r_age[w_tgt]) begin
                            r_age[j] <= r_age[j] + 1'b1;
                        end
                    end
                    r_age[w_tgt]     <= '0;
                    r_vstate[w_tgt]  <= V_HELD;
                    r_note[w_tgt]    <= r_ev_note;
                    r_vel[w_tgt]     <= r_ev_vel;
                    r_note_on[w_tgt] <= 1'b1;
                    r_steal          <= w_steal;
                end else begin
                    r_vstate[w_tgt]   <= V_REL;
                    r_note_off[w_tgt] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        voice_gate     = '0;
        voice_active   = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]             = r_note[i];
            voice_velocity[i*VELOCITY_WIDTH +: VELOCITY_WIDTH] = r_vel[i];
            voice_gate[i]   = (r_vstate[i] == V_HELD);
            voice_active[i] = (r_vstate[i] != V_FREE);
        end
    end

    assign voice_note_on  = r_note_on;
    assign voice_note_off = r_note_off;
    assign steal          = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
//   Directed scenarios with literal expectations, followed by randomized
//   events, envelope ends and occasional resets. A transaction-level model
//   (voice state arrays plus an age queue ordered newest to oldest) predicts
//   every output each cycle.
module tb_voice_allocator;

    localparam int V  = 4;
    localparam int NW = 7;
    localparam int VW = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              event_valid;
    logic              event_ready;
    logic              event_on;
    logic [NW-1:0]     event_note;
    logic [VW-1:0]     event_velocity;
    logic [V-1:0]      envelope_end;
    logic [V-1:0]      voice_note_on;
    logic [V-1:0]      voice_note_off;
    logic [V*NW-1:0]   voice_note;
    logic [V*VW-1:0]   voice_velocity;
    logic [V-1:0]      voice_gate;
    logic [V-1:0]      voice_active;
    logic              steal;

    always #5 clk = ~clk;

    voice_allocator #(
        .VOICES         (V),
        .NOTE_WIDTH     (NW),
        .VELOCITY_WIDTH (VW)
    ) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .event_valid      (event_valid),
        .event_ready      (event_ready),
        .event_on         (event_on),
        .event_note       (event_note),
        .event_velocity   (event_velocity),
        .envelope_end     (envelope_end),
        .voice_note_on    (voice_note_on),
        .voice_note_off   (voice_note_off),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_gate       (voice_gate),
        .voice_active     (voice_active),
        .steal            (steal)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    // m_state: 0 FREE, 1 HELD, 2 RELEASING. Age of a voice is its position
    // in m_order (front = newest).
    int          m_state [V];
    int          m_note  [V];
    int          m_vel   [V];
    int          m_order [$];
    int          m_phase;       // 0 waiting, 1 event pending, 2 result visible
    bit          m_ev_on;
    int          m_ev_note;
    int          m_ev_vel;
    logic [V-1:0] e_on;
    logic [V-1:0] e_off;
    logic        e_steal;
    bit          m_init = 1'b0;

    always @(posedge clk) begin : model
        int  tgt;
        int  pos;
        if (reset) begin
            m_order.delete();
            for (int i = 0; i < V; i++) begin
                m_state[i] = 0;
                m_note[i]  = 0;
                m_vel[i]   = 0;
                m_order.push_back(i);
            end
            m_phase = 0;
            e_on    = '0;
            e_off   = '0;
            e_steal = 1'b0;
            m_init  = 1'b1;
        end else if (m_init) begin
            tgt     = -1;
            e_on    = '0;
            e_off   = '0;
            e_steal = 1'b0;
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (m_ev_on) begin
                    for (int i = V - 1; i >= 0; i--)
                        if (m_state[i] != 0 && m_note[i] == m_ev_note) tgt = i;
                    if (tgt < 0)
                        for (int i = V - 1; i >= 0; i--)
                            if (m_state[i] == 0) tgt = i;
                    if (tgt < 0) begin
                        e_steal = 1'b1;
                        for (int k = 0; k < m_order.size(); k++)
                            if (m_state[m_order[k]] == 2) tgt = m_order[k];
                        if (tgt < 0) tgt = m_order[m_order.size() - 1];
                    end
                    m_state[tgt] = 1;
                    m_note[tgt]  = m_ev_note;
                    m_vel[tgt]   = m_ev_vel;
                    pos = 0;
                    for (int k = 0; k < m_order.size(); k++)
                        if (m_order[k] == tgt) pos = k;
                    m_order.delete(pos);
                    m_order.push_front(tgt);
                    e_on[tgt] = 1'b1;
                end else begin
                    for (int i = V - 1; i >= 0; i--)
                        if (m_state[i] == 1 && m_note[i] == m_ev_note) tgt = i;
                    if (tgt >= 0) begin
                        m_state[tgt] = 2;
                        e_off[tgt]   = 1'b1;
                    end
                end
                m_phase = 2;
            end else if (event_valid) begin
                m_ev_on   = event_on && (event_velocity != 0);
                m_ev_note = int'(event_note);
                m_ev_vel  = int'(event_velocity);
                m_phase   = 1;
            end
            for (int i = 0; i < V; i++)
                if (i != tgt && envelope_end[i] && m_state[i] == 2) m_state[i] = 0;
        end
    end

    always @(negedge clk) begin : compare
        logic [V*NW-1:0] en;
        logic [V*VW-1:0] ev;
        logic [V-1:0]    eg;
        logic [V-1:0]    ea;
        if (m_init) begin
            for (int i = 0; i < V; i++) begin
                en[i*NW +: NW] = NW'(m_note[i]);
                ev[i*VW +: VW] = VW'(m_vel[i]);
                eg[i] = (m_state[i] == 1);
                ea[i] = (m_state[i] != 0);
            end
            cmp("ready",    event_ready,    (m_phase == 0) && !reset);
            cmp("note_on",  voice_note_on,  e_on);
            cmp("note_off", voice_note_off, e_off);
            cmp("steal",    steal,          e_steal);
            cmp("gate",     voice_gate,     eg);
            cmp("active",   voice_active,   ea);
            cmp("note",     voice_note,     en);
            cmp("velocity", voice_velocity, ev);
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic accept(input logic on, input int note, input int vel);
        int g = 0;
        while (!event_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!event_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got 0 expected 1 at t=%0t", $time);
        end
        event_valid    = 1'b1;
        event_on       = on;
        event_note     = NW'(note);
        event_velocity = VW'(vel);
        @(posedge clk);
        @(negedge clk);
        event_valid = 1'b0;
    endtask

    // Returns at the negedge inside the cycle where the pulse is visible.
    task automatic send(input logic on, input int note, input int vel);
        accept(on, note, vel);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        reset          = 1'b1;
        event_valid    = 1'b0;
        event_on       = 1'b0;
        event_note     = '0;
        event_velocity = '0;
        envelope_end   = '0;
        repeat (3) @(negedge clk);
        cmp("rst_ready",  event_ready,  0);
        cmp("rst_active", voice_active, 0);
        cmp("rst_note",   voice_note,   0);
        reset = 1'b0;
        #1;
        cmp("ready_after_rst", event_ready, 1);

        // Basic note-on
        send(1'b1, 60, 100);
        cmp("basic_on",    voice_note_on,   4'b0001);
        cmp("basic_steal", steal,           0);
        cmp("basic_note",  voice_note[6:0], 60);
        cmp("basic_vel",   voice_velocity[6:0], 100);
        cmp("basic_gate",  voice_gate,      4'b0001);

        // Fill and steal oldest
        send(1'b1, 62, 90);
        send(1'b1, 64, 80);
        send(1'b1, 65, 70);
        cmp("fill_on",   voice_note_on, 4'b1000);
        cmp("fill_gate", voice_gate,    4'b1111);
        send(1'b1, 67, 60);
        cmp("steal_on",    voice_note_on,   4'b0001);
        cmp("steal_flag",  steal,           1);
        cmp("steal_note",  voice_note[6:0], 67);

        // Releasing voice preferred over older held voice
        send(1'b0, 62, 0);
        cmp("off62", voice_note_off, 4'b0010);
        send(1'b1, 70, 40);
        cmp("rel_steal_on",   voice_note_on, 4'b0010);
        cmp("rel_steal_flag", steal,         1);
        send(1'b0, 65, 0);
        cmp("off65", voice_note_off, 4'b1000);
        send(1'b1, 72, 30);
        cmp("rel_pref_on",   voice_note_on,    4'b1000);
        cmp("rel_pref_note", voice_note[27:21], 72);

        // Envelope end on a releasing voice
        send(1'b0, 64, 0);
        cmp("off64",      voice_note_off, 4'b0100);
        cmp("rel_active", voice_active,   4'b1111);
        envelope_end = 4'b0100;
        @(negedge clk);
        envelope_end = '0;
        cmp("env_end_active", voice_active, 4'b1011);

        // Retrigger a releasing voice ahead of a free slot
        send(1'b0, 67, 0);
        cmp("off67", voice_note_off, 4'b0001);
        send(1'b1, 67, 50);
        cmp("retrig_on",    voice_note_on,       4'b0001);
        cmp("retrig_steal", steal,               0);
        cmp("retrig_vel",   voice_velocity[6:0], 50);

        // Velocity-0 note-on acts as note-off
        send(1'b1, 67, 0);
        cmp("vel0_off", voice_note_off, 4'b0001);

        // Unmatched note-off
        send(1'b0, 90, 0);
        cmp("unmatched_on",    voice_note_on,  0);
        cmp("unmatched_off",   voice_note_off, 0);
        cmp("unmatched_busy",  event_ready,    0);
        @(negedge clk);
        cmp("unmatched_ready", event_ready,    1);

        // Reset during LOOKUP
        accept(1'b1, 50, 10);
        reset = 1'b1;
        @(negedge clk);
        cmp("midrst_on",     voice_note_on, 0);
        cmp("midrst_steal",  steal,         0);
        cmp("midrst_active", voice_active,  0);
        cmp("midrst_ready",  event_ready,   0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back: valid held high
        event_valid    = 1'b1;
        event_on       = 1'b0;
        event_note     = NW'(99);
        event_velocity = '0;
        acc = 0;
        repeat (12) begin
            if (event_ready) acc++;
            @(negedge clk);
        end
        event_valid = 1'b0;
        cmp("b2b_accepts", acc, 4);
        repeat (3) @(negedge clk);

        // Randomized traffic
        repeat (3000) begin
            reset          = ($urandom_range(0, 299) == 0);
            event_valid    = $urandom_range(0, 1) == 1;
            event_on       = $urandom_range(0, 2) != 0;
            event_note     = NW'($urandom_range(60, 65));
            event_velocity = ($urandom_range(0, 5) == 0) ? '0 : VW'($urandom_range(1, 127));
            envelope_end   = ($urandom_range(0, 3) == 0) ? V'($urandom) : '0;
            @(negedge clk);
        end
        reset        = 1'b0;
        event_valid  = 1'b0;
        envelope_end = '0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
